// File: rtl/median_out_packer.sv
// Packs the raster pixel stream from the median filter into 32-bit words behind a small FIFO,
// tagging the last word of each frame and keeping a per-frame 16-bit pixel checksum.
module median_out_packer #(
    parameter int WIDTH      = 430,
    parameter int HEIGHT     = 554,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  pixel_in,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        frame_done,
    output logic [15:0] checksum,
    output logic        overflow
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

    typedef enum logic {S_RUN, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] pix_cnt;
    logic [1:0]    lane;
    logic [31:0]   pack_q;
    logic [31:0]   word_c;
    logic [15:0]   run_sum;
    logic [AW:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]   pend, pend_nxt;
    logic [32:0]   mem [FIFO_DEPTH];
    logic          last_pix, push, pop, full, wr_en, drop, head_avail;

    always_comb begin
        last_pix   = in_valid && (pix_cnt == LAST_IDX);
        push       = in_valid && ((lane == 2'd3) || last_pix);
        pop        = m_valid && m_ready;
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        wr_en      = push && (!full || pop);
        drop       = push && full && !pop;
        rd_ptr_nxt = rd_ptr + (AW+1)'(pop);
        head_avail = (wr_ptr != rd_ptr_nxt);
        // pend counts stored last-words that the consumer has not yet taken
        pend_nxt   = pend + (AW+1)'(wr_en && last_pix) - (AW+1)'(pop && m_last);
    end

    // Lane 0 starts a fresh word so unwritten lanes of a short final word read as zero.
    always_comb begin
        word_c = (lane == 2'd0) ? 32'h0 : pack_q;
        case (lane)
            2'd0:    word_c[7:0]   = pixel_in;
            2'd1:    word_c[15:8]  = pixel_in;
            2'd2:    word_c[23:16] = pixel_in;
            default: word_c[31:24] = pixel_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt  <= '0;
            lane     <= 2'd0;
            pack_q   <= 32'h0;
            run_sum  <= 16'h0;
            checksum <= 16'h0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend     <= '0;
            m_valid  <= 1'b0;
            m_data   <= 32'h0;
            m_last   <= 1'b0;
            overflow <= 1'b0;
            state    <= S_RUN;
        end else begin
            if (in_valid) begin
                pack_q <= word_c;
                if (last_pix) begin
                    pix_cnt  <= '0;
                    lane     <= 2'd0;
                    run_sum  <= 16'h0;
                    checksum <= run_sum + {8'h0, pixel_in};
                end else begin
                    pix_cnt <= pix_cnt + CW'(1);
                    lane    <= lane + 2'd1;
                    run_sum <= run_sum + {8'h0, pixel_in};
                end
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            rd_ptr  <= rd_ptr_nxt;
            pend    <= pend_nxt;
            // Head register only sees words pushed on an earlier edge: one cycle of latency.
            m_valid <= head_avail;
            if (head_avail) begin
                {m_last, m_data} <= mem[rd_ptr_nxt[AW-1:0]];
            end
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {last_pix, word_c};
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            S_RUN: begin
                if (push && last_pix) begin
                    state_nxt = S_DRAIN;
                end
            end
            default: begin
                frame_done = pop && m_last;
                // A dropped last word leaves pend at zero, so we fall back to RUN next cycle.
                if ((pend_nxt == '0) && !(push && last_pix)) begin
                    state_nxt = S_RUN;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_median_out_packer.sv
// Bench for median_out_packer: three instances (4x2, 3x1, 16x16 with depth-2 FIFO) sharing one
// stimulus path selected by sel; a negedge monitor checks accepted words against an expected queue.
module tb_median_out_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        m_ready;
    logic [7:0]  pixel_in;
    int          sel;

    logic        iv [3];
    logic        mr [3];
    logic        o_valid [3];
    logic [31:0] o_data [3];
    logic        o_last [3];
    logic        o_fd [3];
    logic [15:0] o_cs [3];
    logic        o_ov [3];

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;
    word_t exp_q[$];

    typedef struct {
        logic [63:0] pix;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [15:0] cs;
    } vec_t;
    vec_t tbl [3];

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = in_valid && (sel == i);
            mr[i] = m_ready && (sel == i);
        end
    end

    median_out_packer #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .pixel_in(pixel_in),
        .m_valid(o_valid[0]), .m_ready(mr[0]), .m_data(o_data[0]), .m_last(o_last[0]),
        .frame_done(o_fd[0]), .checksum(o_cs[0]), .overflow(o_ov[0]));

    median_out_packer #(.WIDTH(3), .HEIGHT(1), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .pixel_in(pixel_in),
        .m_valid(o_valid[1]), .m_ready(mr[1]), .m_data(o_data[1]), .m_last(o_last[1]),
        .frame_done(o_fd[1]), .checksum(o_cs[1]), .overflow(o_ov[1]));

    median_out_packer #(.WIDTH(16), .HEIGHT(16), .FIFO_DEPTH(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .pixel_in(pixel_in),
        .m_valid(o_valid[2]), .m_ready(mr[2]), .m_data(o_data[2]), .m_last(o_last[2]),
        .frame_done(o_fd[2]), .checksum(o_cs[2]), .overflow(o_ov[2]));

    always @(negedge clk) begin
        if (!rst) begin
            if (o_fd[sel]) fd_count++;
            if (o_valid[sel] && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word unexpected: got %h last %b, required none", o_data[sel], o_last[sel]);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    if (o_data[sel] !== w.data || o_last[sel] !== w.last) begin
                        errors++;
                        $display("FAIL word: got %h last %b, required %h last %b",
                                 o_data[sel], o_last[sel], w.data, w.last);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] p);
        in_valid = 1'b1;
        pixel_in = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic l);
        word_t w;
        w.data = d;
        w.last = l;
        exp_q.push_back(w);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Inputs toggle during reset to confirm they are ignored.
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        pixel_in = 8'h77;
        m_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        m_ready  = 1'b0;
    endtask

    initial begin
        int fd0;
        tbl[0] = '{pix: 64'h0807060504030201, w0: 32'h04030201, w1: 32'h08070605, cs: 16'h0024};
        tbl[1] = '{pix: 64'hFFFFFFFFFFFFFFFF, w0: 32'hFFFFFFFF, w1: 32'hFFFFFFFF, cs: 16'h07F8};
        tbl[2] = '{pix: 64'h8070605040302010, w0: 32'h40302010, w1: 32'h80706050, cs: 16'h0240};

        sel = 0;
        in_valid = 1'b0;
        pixel_in = 8'h00;
        m_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check("reset m_valid", o_valid[i], 0);
            check("reset m_data", o_data[i], 0);
            check("reset m_last", o_last[i], 0);
            check("reset frame_done", o_fd[i], 0);
            check("reset checksum", o_cs[i], 0);
            check("reset overflow", o_ov[i], 0);
        end

        // 4x2 frames back to back from the vector table
        sel = 0;
        m_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fd0 = fd_count;
            expect_word(tbl[r].w0, 1'b0);
            expect_word(tbl[r].w1, 1'b1);
            for (int i = 0; i < 8; i++) send(tbl[r].pix[8*i +: 8]);
            drain(50);
            idle(2);
            check("table checksum", o_cs[0], tbl[r].cs);
            check("table frame_done count", fd_count - fd0, 1);
        end

        // 3x1 frame with bubbles, partial final word
        sel = 1;
        m_ready = 1'b1;
        fd0 = fd_count;
        expect_word(32'h00CCBBAA, 1'b1);
        send(8'hAA);
        idle(1);
        send(8'hBB);
        idle(2);
        send(8'hCC);
        drain(50);
        idle(2);
        check("partial checksum", o_cs[1], 16'h0231);
        check("partial frame_done count", fd_count - fd0, 1);

        // depth-2 FIFO overflow with consumer stalled
        do_reset();
        sel = 2;
        m_ready = 1'b0;
        expect_word(32'h04030201, 1'b0);
        expect_word(32'h08070605, 1'b0);
        for (int i = 1; i <= 8; i++) send(8'(i));
        idle(2);
        check("ovf before third push", o_ov[2], 0);
        check("ovf head valid", o_valid[2], 1);
        check("ovf head data", o_data[2], 32'h04030201);
        for (int i = 9; i <= 12; i++) send(8'(i));
        idle(1);
        check("ovf after third push", o_ov[2], 1);
        check("ovf head held", o_data[2], 32'h04030201);
        m_ready = 1'b1;
        drain(50);
        idle(3);
        check("ovf sticky", o_ov[2], 1);

        // full FIFO with push and pop in the same cycle
        do_reset();
        sel = 2;
        m_ready = 1'b0;
        expect_word(32'h04030201, 1'b0);
        expect_word(32'h08070605, 1'b0);
        expect_word(32'h0C0B0A09, 1'b0);
        for (int i = 1; i <= 11; i++) send(8'(i));
        idle(2);
        check("full head valid", o_valid[2], 1);
        m_ready = 1'b1;
        send(8'h0C);
        check("push+pop no overflow", o_ov[2], 0);
        drain(50);
        idle(2);
        check("push+pop overflow after drain", o_ov[2], 0);

        // 16x16 frame of 0xFF: checksum wraps
        do_reset();
        sel = 2;
        m_ready = 1'b1;
        fd0 = fd_count;
        for (int k = 0; k < 64; k++) expect_word(32'hFFFFFFFF, k == 63);
        for (int i = 0; i < 256; i++) send(8'hFF);
        drain(100);
        idle(2);
        check("wrap checksum", o_cs[2], 16'hFF00);
        check("wrap overflow", o_ov[2], 0);
        check("wrap frame_done count", fd_count - fd0, 1);

        // reset mid-frame discards partial word and queued word
        sel = 0;
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(8'h50 + i));
        do_reset();
        m_ready = 1'b1;
        fd0 = fd_count;
        expect_word(32'h04030201, 1'b0);
        expect_word(32'h08070605, 1'b1);
        for (int i = 1; i <= 8; i++) send(8'(i));
        drain(50);
        idle(5);
        check("mid-reset checksum", o_cs[0], 16'h0024);
        check("mid-reset frame_done count", fd_count - fd0, 1);
        check("mid-reset overflow", o_ov[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
